// File: rtl/fir_sample_sched.sv
// Sample scheduler and result collector for the 8-channel FIR bank; `SCHED_STATS_EN adds issue/stall counters.
// Latency: push to fb_din_enable 2 cycles when idle; enable rise to out_valid ENABLE_CYCLES+BUSY_CYCLES+1 cycles.
// Backpressure: in_ready drops while the FIFO is full; no sample is issued while out_valid waits on out_ready.
module fir_sample_sched #(
    parameter int FIFO_DEPTH    = 4,
    parameter int ENABLE_CYCLES = 2,
    parameter int BUSY_CYCLES   = 72
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [15:0]  fb_datain,
    output logic         fb_din_enable,
    input  logic [127:0] fb_dataout,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]  stat_samples,
    output logic [15:0]  stat_stall
`endif
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (BUSY_CYCLES > ENABLE_CYCLES) ? BUSY_CYCLES : ENABLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] EN_LOAD   = CW'(ENABLE_CYCLES - 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;

    // count is registered, so a sample pushed this cycle is not visible to pop until the next one.
    assign push = in_valid && in_ready;
    assign pop  = (state == ST_IDLE) && (count != '0) && !out_valid;
    assign busy = (state != ST_IDLE);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            in_ready <= (count_next != FULL_CNT);
        end
    end

    // fb_datain is only written on issue so the bank may sample it anywhere in its start sequence.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            fb_datain     <= '0;
            fb_din_enable <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        fb_datain     <= mem[rd_ptr];
                        fb_din_enable <= 1'b1;
                        cnt           <= EN_LOAD;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cnt == '0) begin
                        fb_din_enable <= 1'b0;
                        cnt           <= BUSY_LOAD;
                        state         <= ST_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    out_data  <= fb_dataout;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_samples <= '0;
            stat_stall   <= '0;
        end else begin
            if (pop && (stat_samples != 16'hFFFF)) begin
                stat_samples <= stat_samples + 16'd1;
            end
            if (in_valid && !in_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_sched.sv
// Bench for fir_sample_sched: scoreboard of issued samples and captured results, timing checks per scenario.
module tb_fir_sample_sched;

    localparam int EN    = 2;
    localparam int BUSY  = 72;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  fb_datain;
    logic         fb_din_enable;
    logic [127:0] fb_dataout;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;
`ifdef SCHED_STATS_EN
    logic [15:0]  stat_samples;
    logic [15:0]  stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stalls = 0;

    logic [15:0]  sample_q[$];
    logic [127:0] res_q[$];
    int           ovt_q[$];
    int           rise_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Filter bank stand-in: output changes every cycle so the capture instant is observable.
    function automatic logic [127:0] pat(input int c);
        logic [127:0] p;
        for (int i = 0; i < 8; i++) p[i*16 +: 16] = 16'(c * 7 + i * 4099 + 165);
        return p;
    endfunction

    assign fb_dataout = pat(cyc);

    fir_sample_sched #(.FIFO_DEPTH(DEPTH), .ENABLE_CYCLES(EN), .BUSY_CYCLES(BUSY)) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fb_datain(fb_datain),
        .fb_din_enable(fb_din_enable),
        .fb_dataout(fb_dataout),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
`ifdef SCHED_STATS_EN
        ,
        .stat_samples(stat_samples),
        .stat_stall(stat_stall)
`endif
    );

    // Scoreboard monitor on the falling edge.
    logic         prev_en = 1'b0;
    logic         prev_ov = 1'b0;
    logic         prev_hs = 1'b0;
    int           en_len  = 0;
    logic [127:0] held    = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_en = 1'b0;
            prev_ov = 1'b0;
            prev_hs = 1'b0;
            en_len  = 0;
        end else begin
            if (fb_din_enable && !prev_en) begin
                logic [15:0] exp_s;
                rise_q.push_back(cyc);
                checks++;
                if (sample_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_order: unexpected issue fb_datain=%h with no sample pending", fb_datain);
                end else begin
                    exp_s = sample_q.pop_front();
                    if (fb_datain !== exp_s) begin
                        errors++;
                        $display("FAIL issue_order: fb_datain=%h expected %h", fb_datain, exp_s);
                    end
                end
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL issue_while_valid: out_valid=%b expected 0", out_valid);
                end
                res_q.push_back(pat(cyc + EN + BUSY));
                ovt_q.push_back(cyc + EN + BUSY + 1);
                en_len = 0;
            end
            if (fb_din_enable) en_len++;
            if (!fb_din_enable && prev_en) begin
                checks++;
                if (en_len != EN) begin
                    errors++;
                    $display("FAIL enable_width: %0d cycles expected %0d", en_len, EN);
                end
            end
            if (out_valid && !prev_ov) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: out_valid rose with no result pending");
                end else begin
                    int t;
                    held = res_q.pop_front();
                    t = ovt_q.pop_front();
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL result_data: out_data=%h expected %h", out_data, held);
                    end
                    checks++;
                    if (cyc != t) begin
                        errors++;
                        $display("FAIL result_time: out_valid at cycle %0d expected %0d", cyc, t);
                    end
                end
            end else if (out_valid && prev_ov) begin
                checks++;
                if (out_data !== held) begin
                    errors++;
                    $display("FAIL result_stable: out_data=%h expected %h", out_data, held);
                end
            end
            if (!out_valid && prev_ov) begin
                checks++;
                if (!prev_hs) begin
                    errors++;
                    $display("FAIL valid_drop: out_valid cleared without handshake, hs=%b expected 1", prev_hs);
                end
            end
            prev_en = fb_din_enable;
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_sb();
        sample_q.delete();
        res_q.delete();
        ovt_q.delete();
    endtask

    task automatic push_one(input logic [15:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            stalls++;
            tick();
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout: data=%h in_ready=%b expected 1", d, in_ready);
            in_valid = 1'b0;
            return;
        end
        sample_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(sample_q.size() == 0 && res_q.size() == 0 && !busy && !out_valid) && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL wait_idle: timeout pending_samples=%0d pending_results=%0d busy=%b expected idle",
                     sample_q.size(), res_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        clear_sb();
        checks += 6;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: %b expected 1", in_ready); end
        if (fb_din_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: %b expected 0", fb_din_enable); end
        if (fb_datain !== 16'h0) begin errors++; $display("FAIL reset_datain: %h expected 0000", fb_datain); end
        if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: %h expected 0", out_data); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: %b expected 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b expected 0", busy); end
`ifdef SCHED_STATS_EN
        checks += 2;
        if (stat_samples !== 16'h0) begin errors++; $display("FAIL reset_stat_samples: %h expected 0", stat_samples); end
        if (stat_stall !== 16'h0) begin errors++; $display("FAIL reset_stat_stall: %h expected 0", stat_stall); end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        out_ready = 1'b1;
        push_one(16'h1234);
        checks += 2;
        if (fb_din_enable !== 1'b0) begin errors++; $display("FAIL single_early_enable: %b expected 0", fb_din_enable); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_early_busy: %b expected 0", busy); end
        tick();
        checks += 3;
        if (fb_din_enable !== 1'b1) begin errors++; $display("FAIL single_enable: %b expected 1", fb_din_enable); end
        if (fb_datain !== 16'h1234) begin errors++; $display("FAIL single_datain: %h expected 1234", fb_datain); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: %b expected 1", busy); end
        tick();
        checks++;
        if (fb_din_enable !== 1'b1) begin errors++; $display("FAIL single_enable_hold: %b expected 1", fb_din_enable); end
        tick();
        checks++;
        if (fb_din_enable !== 1'b0) begin errors++; $display("FAIL single_enable_drop: %b expected 0", fb_din_enable); end
        n = 2;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != EN + BUSY + 1) begin
            errors++;
            $display("FAIL single_latency: out_valid after %0d cycles expected %0d", n, EN + BUSY + 1);
        end
        wait_idle(300);
    endtask

    task automatic test_fifo_full();
        int n = 0;
        out_ready = 1'b1;
        push_one(16'hA000);
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        for (int i = 1; i <= 4; i++) push_one(16'(i));
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: %b expected 0", in_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: %b expected 1", busy); end
        stalls = 0;
        push_one(16'h0005);
        // Slot frees at the issue following the A000 handshake: 73 blocked cycles.
        checks++;
        if (stalls != 73) begin errors++; $display("FAIL full_stall_cycles: %0d expected 73", stalls); end
        wait_idle(1000);
    endtask

    task automatic test_hold();
        int rises;
        int n = 0;
        out_ready = 1'b0;
        push_one(16'hB001);
        push_one(16'hB002);
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL hold_first_result: out_valid=%b expected 1", out_valid); end
        rises = rise_q.size();
        repeat (200) tick();
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: %b expected 1", out_valid); end
        if (rise_q.size() != rises) begin
            errors++;
            $display("FAIL hold_no_issue: %0d enable pulses expected %0d", rise_q.size(), rises);
        end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_clear: out_valid=%b expected 0", out_valid); end
        if (fb_din_enable !== 1'b0) begin errors++; $display("FAIL hold_issue_early: %b expected 0", fb_din_enable); end
        tick();
        checks += 2;
        if (fb_din_enable !== 1'b1) begin errors++; $display("FAIL hold_issue: %b expected 1", fb_din_enable); end
        if (fb_datain !== 16'hB002) begin errors++; $display("FAIL hold_datain: %h expected b002", fb_datain); end
        wait_idle(300);
    endtask

    task automatic test_reset_wait();
        int seen = 0;
        out_ready = 1'b1;
        push_one(16'hC001);
        tick();
        push_one(16'hC002);
        // Reset lands in WAIT with cnt=30.
        repeat (42) tick();
        reset = 1'b1;
        tick();
        clear_sb();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid: %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_in_ready: %b expected 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: %b expected 0", busy); end
        if (fb_din_enable !== 1'b0) begin errors++; $display("FAIL rst_wait_enable: %b expected 0", fb_din_enable); end
        if (fb_datain !== 16'h0) begin errors++; $display("FAIL rst_wait_datain: %h expected 0000", fb_datain); end
        reset = 1'b0;
        repeat (150) begin
            tick();
            if (out_valid || fb_din_enable) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_wait_quiet: %0d active cycles expected 0", seen); end
    endtask

    task automatic test_stream();
        int base;
        out_ready = 1'b1;
        base = rise_q.size();
        for (int i = 0; i < 6; i++) push_one(16'hD000 + 16'(i));
        wait_idle(1500);
        checks++;
        if (rise_q.size() != base + 6) begin
            errors++;
            $display("FAIL stream_count: %0d issues expected 6", rise_q.size() - base);
        end else begin
            for (int i = base + 1; i < base + 6; i++) begin
                checks++;
                if (rise_q[i] - rise_q[i-1] != EN + BUSY + 3) begin
                    errors++;
                    $display("FAIL stream_period: gap %0d expected %0d", rise_q[i] - rise_q[i-1], EN + BUSY + 3);
                end
            end
        end
    endtask

`ifdef SCHED_STATS_EN
    task automatic test_stats();
        test_reset();
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_one(16'hE000 + 16'(i));
        wait_idle(2000);
        checks += 2;
        if (stat_samples !== 16'd10) begin errors++; $display("FAIL stats_samples: %0d expected 10", stat_samples); end
        if (stat_stall !== 16'(stalls)) begin errors++; $display("FAIL stats_stall: %0d expected %0d", stat_stall, stalls); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_hold();
        test_reset_wait();
        test_stream();
`ifdef SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
